// File: rtl/lsu_pkg.sv
// lsu_pkg: constants and types shared by the load/store unit and its bench.
//   - RW_READ / RW_WRITE : memory direction encoding (mem_read_write)
//   - F3_*               : RV32I load/store funct3 codes
//   - lsu_state_e        : master FSM state encoding
//   - HALF_CYCLE         : half clock period used by benches
//   - f3_illegal()       : funct3 legality check for a load or a store
package lsu_pkg;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RMWR  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

    localparam int HALF_CYCLE = 5;

    // Codes 3/6/7 are never legal; stores have no unsigned variants.
    function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (store && (f3 > F3_W));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
// Ports:
//   i_funct3     : access size/signedness (F3_*)
//   i_addr_lo    : byte offset within the word
//   i_rword      : word read from memory
//   i_wdata      : store data (low bits used for B/H)
//   o_load_data  : selected lane, sign- or zero-extended
//   o_store_word : i_rword with the addressed lane(s) replaced (or i_wdata for W)
//   o_misalign   : halfword on odd address or word not 4-byte aligned
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian: byte lane k lives at bits [8k+7:8k].
    assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rword[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_load_data = i_rword;
        unique case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'd0, w_half};
            default: o_load_data = i_rword;
        endcase
    end

    always_comb begin
        o_store_word = i_rword;
        unique case (i_funct3)
            F3_B:    o_store_word[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            F3_H:    o_store_word[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_store_word = i_wdata;
        endcase
    end

    always_comb begin
        o_misalign = 1'b0;
        if ((i_funct3 == F3_H) || (i_funct3 == F3_HU)) begin
            o_misalign = i_addr_lo[0];
        end else if (i_funct3 == F3_W) begin
            o_misalign = (i_addr_lo != 2'b00);
        end
    end

endmodule

// File: rtl/mem_lsu_master.sv
// mem_lsu_master: RV32I load/store unit driving a word-wide memory port.
// Sub-word stores are done as read-modify-write since memory writes 4 bytes.
// Ports:
//   clock, reset_n          : clock, synchronous active-low reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_store, req_funct3   : operation select
//   req_addr, req_wdata     : byte address and store data
//   rsp_valid               : one-cycle completion pulse
//   rsp_rdata, rsp_error    : extended load data / misaligned-or-illegal flag
//   mem_address             : word-aligned memory address
//   mem_data_in             : write data to memory
//   mem_data_out            : combinational read data from memory
//   mem_read_write          : 0 = read, 1 = write (commits on posedge)
module mem_lsu_master
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
    parameter int unsigned XLEN      = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_error,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_data_in,
    input  logic [XLEN-1:0] mem_data_out,
    output logic            mem_read_write
);

    lsu_state_e  r_state;
    lsu_state_e  w_state_d;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_rdata;
    logic        r_error;

    logic [2:0]  w_al_funct3;
    logic [1:0]  w_al_addr_lo;
    logic [31:0] w_load_data;
    logic [31:0] w_store_word;
    logic        w_misalign;
    logic        w_illegal;

    // In IDLE the aligner checks the incoming request; afterwards it works
    // on the captured operation.
    assign w_al_funct3  = (r_state == IDLE) ? req_funct3    : r_funct3;
    assign w_al_addr_lo = (r_state == IDLE) ? req_addr[1:0] : r_addr_lo;

    lsu_align u_align (
        .i_funct3     (w_al_funct3),
        .i_addr_lo    (w_al_addr_lo),
        .i_rword      (mem_data_out),
        .i_wdata      (r_mem_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word),
        .o_misalign   (w_misalign)
    );

    assign w_illegal = f3_illegal(req_store, req_funct3) || w_misalign;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_illegal) begin
                        w_state_d = RESP;
                    end else if (!req_store) begin
                        w_state_d = LOAD;
                    end else if (req_funct3 == F3_W) begin
                        w_state_d = WRITE;
                    end else begin
                        w_state_d = RMWR;
                    end
                end
            end
            LOAD:    w_state_d = RESP;
            RMWR:    w_state_d = WRITE;
            WRITE:   w_state_d = RESP;
            RESP:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_funct3    <= F3_B;
            r_addr_lo   <= 2'b00;
            r_mem_addr  <= BASE_ADDR;
            r_mem_wdata <= 32'd0;
            r_rdata     <= 32'd0;
            r_error     <= 1'b0;
        end else begin
            r_state <= w_state_d;
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_funct3  <= req_funct3;
                        r_addr_lo <= req_addr[1:0];
                        r_rdata   <= 32'd0;
                        r_error   <= w_illegal;
                        // Rejected requests never touch the memory port.
                        if (!w_illegal) begin
                            r_mem_addr <= {req_addr[31:2], 2'b00};
                            if (req_store) begin
                                r_mem_wdata <= req_wdata;
                            end
                        end
                    end
                end
                LOAD:    r_rdata     <= w_load_data;
                RMWR:    r_mem_wdata <= w_store_word;
                default: ;
            endcase
        end
    end

    assign req_ready   = (r_state == IDLE);
    assign rsp_valid   = (r_state == RESP);
    assign rsp_rdata   = r_rdata;
    assign rsp_error   = r_error;
    assign mem_address = r_mem_addr;
    assign mem_data_in = r_mem_wdata;
    // Gated with reset so an edge with reset asserted never writes memory.
    assign mem_read_write = ((r_state == WRITE) ? RW_WRITE : RW_READ) && reset_n;

endmodule

// File: tb/tb_mem_lsu_master.sv
// tb_mem_lsu_master: self-checking bench for mem_lsu_master with a small
// word memory model and a scoreboard queue of expected responses.
module tb_mem_lsu_master;
    import lsu_pkg::*;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = BASE;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_read_write;

    logic [31:0] mem [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [31:0] pl_data = 32'd0;

    int n_vec = 0;
    int n_err = 0;
    int wr_count = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    mem_lsu_master #(
        .BASE_ADDR (BASE),
        .XLEN      (32)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_error      (rsp_error),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_read_write (mem_read_write)
    );

    always #HALF_CYCLE clock = ~clock;

    always @(posedge clock) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_read_write) begin
            mem[mem_address[5:2]] <= mem_data_in;
        end
    end

    assign mem_data_out = mem[mem_address[5:2]];

    always @(negedge clock) begin
        if (mem_read_write) wr_count++;
    end

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        pl_en = 1'b1;
        pl_idx = idx;
        pl_data = data;
        @(posedge clock);
        #1 pl_en = 1'b0;
    endtask

    task automatic check_mem(input logic [3:0] idx, input logic [31:0] exp, input string name);
        n_vec++;
        if (mem[idx] !== exp) begin
            n_err++;
            $display("FAIL %s: memory word is %h, expected %h", name, mem[idx], exp);
        end
    endtask

    // Single request: accept, scoreboard push, latency, response, write count.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat, input int exp_wr,
                          input string name);
        exp_t e;
        int   lat;
        int   wr0;
        bit   got;
        req_store = st;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (req_ready) begin
                got = 1;
                break;
            end
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL %s accept: req_ready is 0, expected 1", name);
            req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        wr0 = wr_count;
        e.rdata = exp_rdata;
        e.err = exp_err;
        sb_q.push_back(e);
        #1 req_valid = 1'b0;
        lat = 0;
        got = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (rsp_valid) begin
                lat = i;
                got = 1;
                break;
            end
        end
        n_vec++;
        if (lat != exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, exp_lat);
        end
        if (got) begin
            e = sb_q.pop_front();
            n_vec++;
            if (rsp_rdata !== e.rdata) begin
                n_err++;
                $display("FAIL %s rdata: got %h, expected %h", name, rsp_rdata, e.rdata);
            end
            n_vec++;
            if (rsp_error !== e.err) begin
                n_err++;
                $display("FAIL %s error: got %b, expected %b", name, rsp_error, e.err);
            end
        end else begin
            sb_q.delete();
        end
        n_vec++;
        if (wr_count - wr0 != exp_wr) begin
            n_err++;
            $display("FAIL %s write cycles: got %0d, expected %0d", name, wr_count - wr0, exp_wr);
        end
        @(negedge clock);
        n_vec++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s pulse end: valid=%b ready=%b, expected valid=0 ready=1",
                     name, rsp_valid, req_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL %s req_ready: got %b, expected 1", name, req_ready);
        end
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL %s rsp_valid: got %b, expected 0", name, rsp_valid);
        end
        n_vec++;
        if (rsp_rdata !== 32'd0) begin
            n_err++; $display("FAIL %s rsp_rdata: got %h, expected 0", name, rsp_rdata);
        end
        n_vec++;
        if (rsp_error !== 1'b0) begin
            n_err++; $display("FAIL %s rsp_error: got %b, expected 0", name, rsp_error);
        end
        n_vec++;
        if (mem_address !== BASE) begin
            n_err++; $display("FAIL %s mem_address: got %h, expected %h", name, mem_address, BASE);
        end
        n_vec++;
        if (mem_data_in !== 32'd0) begin
            n_err++; $display("FAIL %s mem_data_in: got %h, expected 0", name, mem_data_in);
        end
        n_vec++;
        if (mem_read_write !== 1'b0) begin
            n_err++;
            $display("FAIL %s mem_read_write: got %b, expected 0", name, mem_read_write);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_loads();
        preload(4'd0, 32'hA1B2_C3D4);
        do_req(1'b0, F3_B,  BASE + 3, 32'd0, 32'hFFFF_FFA1, 1'b0, 2, 0, "LB@3");
        do_req(1'b0, F3_BU, BASE + 0, 32'd0, 32'h0000_00D4, 1'b0, 2, 0, "LBU@0");
        do_req(1'b0, F3_H,  BASE + 2, 32'd0, 32'hFFFF_A1B2, 1'b0, 2, 0, "LH@2");
        do_req(1'b0, F3_HU, BASE + 0, 32'd0, 32'h0000_C3D4, 1'b0, 2, 0, "LHU@0");
        do_req(1'b0, F3_W,  BASE + 0, 32'd0, 32'hA1B2_C3D4, 1'b0, 2, 0, "LW@0");
    endtask

    task automatic test_stores();
        do_req(1'b1, F3_B, BASE + 1, 32'hFFFF_FF5A, 32'd0, 1'b0, 3, 1, "SB@1");
        check_mem(4'd0, 32'hA1B2_5AD4, "SB@1 mem");
        preload(4'd0, 32'hA1B2_C3D4);
        do_req(1'b1, F3_H, BASE + 2, 32'hABCD_1234, 32'd0, 1'b0, 3, 1, "SH@2");
        check_mem(4'd0, 32'h1234_C3D4, "SH@2 mem");
        do_req(1'b1, F3_W, BASE + 4, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 1, "SW@4");
        check_mem(4'd1, 32'hDEAD_BEEF, "SW@4 mem");
        do_req(1'b0, F3_W, BASE + 4, 32'd0, 32'hDEAD_BEEF, 1'b0, 2, 0, "LW@4");
    endtask

    task automatic test_errors();
        do_req(1'b0, F3_W, BASE + 2, 32'd0, 32'd0, 1'b1, 1, 0, "LW@2 err");
        do_req(1'b1, F3_H, BASE + 1, 32'h0000_5555, 32'd0, 1'b1, 1, 0, "SH@1 err");
        do_req(1'b0, 3'd3, BASE + 0, 32'd0, 32'd0, 1'b1, 1, 0, "f3=3 err");
        do_req(1'b1, F3_BU, BASE + 0, 32'h0000_0077, 32'd0, 1'b1, 1, 0, "store f3=4 err");
        check_mem(4'd0, 32'h1234_C3D4, "errors mem");
    endtask

    task automatic test_reset_mid_rmw();
        int  wr0;
        bit  got;
        preload(4'd0, 32'hA1B2_C3D4);
        req_store = 1'b1;
        req_funct3 = F3_B;
        req_addr = BASE;
        req_wdata = 32'h0000_0077;
        req_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (req_ready) begin
                got = 1;
                break;
            end
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL rst-rmw accept: req_ready is 0, expected 1");
        end
        @(posedge clock);
        wr0 = wr_count;
        #1 req_valid = 1'b0;
        @(posedge clock);
        #1;
        n_vec++;
        if (mem_read_write !== 1'b1) begin
            n_err++;
            $display("FAIL rst-rmw in WRITE: mem_read_write is %b, expected 1", mem_read_write);
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (mem_read_write !== 1'b0) begin
            n_err++;
            $display("FAIL rst-rmw gated: mem_read_write is %b, expected 0", mem_read_write);
        end
        @(posedge clock);
        @(negedge clock);
        check_reset_outputs("rst-rmw");
        check_mem(4'd0, 32'hA1B2_C3D4, "rst-rmw mem");
        n_vec++;
        if (wr_count != wr0) begin
            n_err++;
            $display("FAIL rst-rmw write cycles: got %0d, expected %0d", wr_count - wr0, 0);
        end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_back_to_back();
        logic        st   [4];
        logic [2:0]  f3   [4];
        logic [31:0] ad   [4];
        logic [31:0] wd   [4];
        logic [31:0] exr  [4];
        int          pulses;
        st[0] = 1'b0; f3[0] = F3_W;  ad[0] = BASE + 0; wd[0] = 32'd0;         exr[0] = 32'hA1B2_C3D4;
        st[1] = 1'b0; f3[1] = F3_BU; ad[1] = BASE + 1; wd[1] = 32'd0;         exr[1] = 32'h0000_00C3;
        st[2] = 1'b1; f3[2] = F3_W;  ad[2] = BASE + 8; wd[2] = 32'h1122_3344; exr[2] = 32'd0;
        st[3] = 1'b0; f3[3] = F3_W;  ad[3] = BASE + 8; wd[3] = 32'd0;         exr[3] = 32'h1122_3344;
        pulses = 0;
        fork
            begin
                for (int r = 0; r < 4; r++) begin
                    bit   ok;
                    exp_t e;
                    req_store = st[r];
                    req_funct3 = f3[r];
                    req_addr = ad[r];
                    req_wdata = wd[r];
                    req_valid = 1'b1;
                    ok = 0;
                    for (int i = 0; i < 10; i++) begin
                        @(negedge clock);
                        if (req_ready) begin
                            ok = 1;
                            break;
                        end
                    end
                    n_vec++;
                    if (!ok) begin
                        n_err++;
                        $display("FAIL b2b accept %0d: req_ready is 0, expected 1", r);
                        break;
                    end
                    @(posedge clock);
                    e.rdata = exr[r];
                    e.err = 1'b0;
                    sb_q.push_back(e);
                    #1;
                end
                req_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    exp_t e;
                    @(negedge clock);
                    if (rsp_valid) begin
                        pulses++;
                        n_vec++;
                        if (req_ready !== 1'b0) begin
                            n_err++;
                            $display("FAIL b2b ready in RESP: got %b, expected 0", req_ready);
                        end
                        n_vec++;
                        if (sb_q.size() == 0) begin
                            n_err++;
                            $display("FAIL b2b extra response: rdata %h, expected none", rsp_rdata);
                        end else begin
                            e = sb_q.pop_front();
                            if (rsp_rdata !== e.rdata || rsp_error !== e.err) begin
                                n_err++;
                                $display("FAIL b2b response %0d: got %h/%b, expected %h/%b",
                                         pulses, rsp_rdata, rsp_error, e.rdata, e.err);
                            end
                        end
                    end
                end
            end
        join
        n_vec++;
        if (pulses != 4) begin
            n_err++;
            $display("FAIL b2b pulse count: got %0d, expected 4", pulses);
        end
        check_mem(4'd2, 32'h1122_3344, "b2b SW mem");
        sb_q.delete();
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_reset_mid_rmw();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
